// File: rtl/cotm32_mdu_iter.sv
// cotm32_mdu_iter -- iterative RV32M multiply/divide unit (EX stage).
//
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
// Operands are reduced to magnitudes on acceptance, an unsigned core runs
// WIDTH iterations, and the sign is reapplied when the result is formed.
// Divide-by-zero and signed overflow are resolved without iterating.
//
// Ports:
//   clk     core clock, rising edge
//   rst     asynchronous active-high reset
//   start   request, accepted when idle, op != MU_NOP and kill is low
//   op      mu_op_t operation, sampled on the accepting edge
//   a, b    rs1 / rs2 (multiplicand / multiplier, dividend / divisor)
//   kill    flush; aborts the operation in flight, wins over start
//   busy    high while an operation is calculating or completing
//   done    one-cycle pulse, result valid in that cycle
//   result  result; held until the next completed operation

package cotm32_mdu_pkg;
    typedef enum logic [3:0] {
        MU_NOP    = 4'd0,
        MU_MUL    = 4'd1,
        MU_MULH   = 4'd2,
        MU_MULHSU = 4'd3,
        MU_MULHU  = 4'd4,
        MU_DIV    = 4'd5,
        MU_DIVU   = 4'd6,
        MU_REM    = 4'd7,
        MU_REMU   = 4'd8
    } mu_op_t;
endpackage

module cotm32_mdu_iter
    import cotm32_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  mu_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_nxt;
    mu_op_t           op_q;
    logic             neg_q;
    logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_pend_q;
    logic [WIDTH-1:0] result_q;

    // Acceptance-side decode
    logic             accept, special, is_mul_in, is_div_in;
    logic             a_neg, b_neg, neg_in;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;

    // One iteration of the unsigned core plus the signed final result
    logic             last_iter;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo, final_res;
    logic [2*WIDTH-1:0] prod, prod_s;

    always_comb begin
        is_mul_in = op inside {MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU};
        is_div_in = op inside {MU_DIV, MU_DIVU, MU_REM, MU_REMU};
        a_neg = (op inside {MU_MUL, MU_MULH, MU_MULHSU, MU_DIV, MU_REM}) && a[WIDTH-1];
        b_neg = (op inside {MU_MUL, MU_MULH, MU_DIV, MU_REM}) && b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
        // Remainder follows the dividend; everything else is sign(a)^sign(b).
        neg_in = (op inside {MU_REM, MU_REMU}) ? a_neg : (a_neg ^ b_neg);

        special     = 1'b0;
        special_res = '0;
        if (is_div_in && (b == '0)) begin
            special     = 1'b1;
            special_res = (op inside {MU_DIV, MU_DIVU}) ? '1 : a;
        end else if ((op inside {MU_DIV, MU_REM}) &&
                     (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) begin
            special     = 1'b1;
            special_res = (op == MU_DIV) ? a : '0;
        end

        accept = (state_q == S_IDLE) && start && (op != MU_NOP) && !kill;
    end

    always_comb begin
        last_iter = (cnt_q == CW'(WIDTH-1));

        // Multiply: {hi,lo} shifts right, multiplier bits consumed from lo[0].
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

        // Divide: remainder in hi, dividend shifts out of lo as quotient shifts in.
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};

        if (op_q inside {MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU}) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
        end

        prod   = {step_hi, step_lo};
        prod_s = neg_q ? -prod : prod;

        case (op_q)
            MU_MUL:                       final_res = prod_s[WIDTH-1:0];
            MU_MULH, MU_MULHSU, MU_MULHU: final_res = prod_s[2*WIDTH-1:WIDTH];
            MU_DIV, MU_DIVU:              final_res = neg_q ? -step_lo : step_lo;
            MU_REM, MU_REMU:              final_res = neg_q ? -step_hi : step_hi;
            default:                      final_res = '0;
        endcase
    end

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (kill)           state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= MU_NOP;
            neg_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
            res_pend_q <= '0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                op_q  <= op;
                neg_q <= neg_in;
                cnt_q <= '0;
                hi_q  <= '0;
                if (is_mul_in) begin
                    mcand_q <= mag_a;
                    lo_q    <= mag_b;
                end else begin
                    lo_q    <= mag_a;
                    mcand_q <= mag_b;
                end
                if (special) res_pend_q <= special_res;
            end else if ((state_q == S_CALC) && !kill) begin
                hi_q  <= step_hi;
                lo_q  <= step_lo;
                cnt_q <= cnt_q + CW'(1);
                if (last_iter) res_pend_q <= final_res;
            end

            // The visible result only commits when done actually pulses, so a
            // kill during DONE leaves the previous value in place.
            if ((state_q == S_DONE) && !kill) result_q <= res_pend_q;
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE) && !kill;
        result = done ? res_pend_q : result_q;
    end

endmodule

// File: tb/tb_cotm32_mdu_iter.sv
// Self-checking bench for cotm32_mdu_iter: expected results and completion
// cycles are queued when a request is driven and matched on each done pulse.
module tb_cotm32_mdu_iter;
    import cotm32_mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         kill = 1'b0;
    mu_op_t       op = MU_NOP;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] result;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    cotm32_mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .kill(kill), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued request.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.tag, result, e.res);
                check({e.tag, "_lat"}, W'(cyc), W'(e.due));
            end
        end
    end

    // lat = number of edges from the accepting edge (inclusive) to done.
    task automatic issue(input string tag, input mu_op_t o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp,
                         input int lat, input bit track);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        if (track) sb_q.push_back('{tag, exp, cyc + lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, W'(busy), 32'd1);
    endtask

    // Scrambles a/b/op every cycle while waiting to prove only latched values matter.
    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            a  = $urandom;
            b  = $urandom;
            op = mu_op_t'($urandom_range(1, 8));
            @(posedge clk);
            #1;
            idle = !busy;
        end
        check({tag, "_idle"}, W'(idle), 32'd1);
    endtask

    task automatic run(input string tag, input mu_op_t o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] exp, input int lat);
        issue(tag, o, x, y, exp, lat, 1'b1);
        wait_idle(tag);
    endtask

    initial begin
        bit           busy_all;
        logic [W-1:0] x, y;
        logic [63:0]  p;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), 32'd0);
        check("rst_done", W'(done), 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // MUL 7 * -3 with busy tracked across the whole operation
        issue("mul_7_m3", MU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
        busy_all = 1'b1;
        for (int e = 2; e <= 33; e++) begin
            @(posedge clk);
            #1;
            busy_all &= busy;
        end
        check("mul_busy_span", W'(busy_all), 32'd1);
        @(posedge clk);
        #1;
        check("mul_busy_end", W'(busy), 32'd0);

        run("mulh_m1", MU_MULH, '1, '1, 32'h0000_0000, 33);
        run("mulhu_m1", MU_MULHU, '1, '1, 32'hFFFF_FFFE, 33);
        run("mulhsu_m1", MU_MULHSU, '1, '1, 32'hFFFF_FFFF, 33);
        run("div_m7_2", MU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem_m7_2", MU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("remu_100_7", MU_REMU, 32'd100, 32'd7, 32'd2, 33);
        run("divu_100_7", MU_DIVU, 32'd100, 32'd7, 32'd14, 33);

        // kill while iteration 10 is being computed
        issue("kill_divu", MU_DIVU, 32'd1000, 32'd3, '0, 33, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        check("kill_busy", W'(busy), 32'd0);
        check("kill_done", W'(done), 32'd0);
        check("kill_result", result, 32'd14);

        // kill and start together in idle: request not accepted
        @(negedge clk);
        op = MU_MUL; a = 32'd2; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check("kill_start_ign", W'(busy), 32'd0);

        run("mul_3_4", MU_MUL, 32'd3, 32'd4, 32'd12, 33);

        // special cases; a start during the DONE cycle is ignored
        issue("div_5_0", MU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        @(negedge clk);
        op = MU_MUL; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_start_ign", W'(busy), 32'd0);
        check("done_held", result, 32'hFFFF_FFFF);

        run("remu_5_0", MU_REMU, 32'd5, 32'd0, 32'd5, 1);
        run("div_ovf", MU_DIV, 32'h8000_0000, '1, 32'h8000_0000, 1);
        run("rem_ovf", MU_REM, 32'h8000_0000, '1, 32'd0, 1);

        // MU_NOP start is ignored
        @(negedge clk);
        op = MU_NOP; a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("nop_ign", W'(busy), 32'd0);

        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom;
            p = {32'd0, x} * {32'd0, y};
            run("rnd_mulhu", MU_MULHU, x, y, p[63:32], 33);
            y = W'($urandom_range(1, 32'hFFFF));
            run("rnd_divu", MU_DIVU, x, y, x / y, 33);
        end

        // asynchronous reset in the middle of CALC
        issue("rst_mid", MU_MUL, 32'd5, 32'd6, '0, 33, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", W'(busy), 32'd0);
        check("rst_mid_done", W'(done), 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", W'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
